// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: op vector width, one-hot bit positions,
// response latency and the one-hot validity check.
package alu_defs;

    localparam int OP_W    = 12;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_LUI  = 11;

    // Cycles from request acceptance to the response slot showing valid.
    localparam int RSP_LAT = 1;

    // True when exactly one op bit is set (nonzero, and clearing the lowest
    // set bit leaves nothing).
    function automatic logic onehot(input logic [OP_W-1:0] op);
        return (op != '0) && ((op & (op - {{(OP_W-1){1'b0}}, 1'b1})) == '0);
    endfunction

endpackage

// File: rtl/alu_arb_alu.sv
// Shared combinational ALU. Shift amount comes from src1[4:0]; the shifted
// value and the lui immediate come from src2. A non-one-hot op produces a
// don't-care result that the arbiter masks off.
module alu
    import alu_defs::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     src1,
    input  logic [31:0]     src2,
    output logic [31:0]     result
);

    // Select the operation by its one-hot bit.
    always_comb begin
        result = '0;
        case (1'b1)
            op[OP_ADD]:  result = src1 + src2;
            op[OP_SUB]:  result = src1 - src2;
            op[OP_SLT]:  result = {31'b0, $signed(src1) < $signed(src2)};
            op[OP_SLTU]: result = {31'b0, src1 < src2};
            op[OP_AND]:  result = src1 & src2;
            op[OP_NOR]:  result = ~(src1 | src2);
            op[OP_OR]:   result = src1 | src2;
            op[OP_XOR]:  result = src1 ^ src2;
            op[OP_SLL]:  result = src2 << src1[4:0];
            op[OP_SRL]:  result = src2 >> src1[4:0];
            op[OP_SRA]:  result = $unsigned($signed(src2) >>> src1[4:0]);
            op[OP_LUI]:  result = {src2[15:0], 16'h0000};
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb.sv
// Two-requester round-robin front end for one shared ALU. Each requester
// owns a one-entry response slot that fills one cycle after acceptance and
// drains on its consumer's ready. Malformed ops complete with err=1 and a
// zero result; cycles where both ports were eligible are counted.
module alu_arb
    import alu_defs::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [31:0]       req0_src1,
    input  logic [31:0]       req0_src2,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [31:0]       req1_src1,
    input  logic [31:0]       req1_src2,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [31:0]       rsp0_result,
    output logic [TAG_W-1:0]  rsp0_tag,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [31:0]       rsp1_result,
    output logic [TAG_W-1:0]  rsp1_tag,
    output logic              rsp1_err,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic             last_grant_reg;   // 1: port 1 was granted most recently
    logic [CNT_W-1:0] conflict_cnt_reg;

    logic [OP_W-1:0]  alu_op;
    logic [31:0]      alu_src1;
    logic [31:0]      alu_src2;
    logic [31:0]      alu_result;
    logic [TAG_W-1:0] sel_tag;
    logic             op_ok;
    logic [31:0]      slot_result_next;

    logic             rsp_valid_reg  [2];
    logic [31:0]      rsp_result_reg [2];
    logic [TAG_W-1:0] rsp_tag_reg    [2];
    logic             rsp_err_reg    [2];

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // Round-robin: a lone eligible port wins; on a tie the port that did not
    // win last time takes the grant.
    always_comb begin
        grant    = 2'b00;
        grant[0] = eligible[0] & (~eligible[1] | last_grant_reg);
        grant[1] = eligible[1] & (~eligible[0] | ~last_grant_reg);
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Operand mux: port 0 drives the ALU unless port 1 holds the grant.
    always_comb begin
        alu_op   = req0_op;
        alu_src1 = req0_src1;
        alu_src2 = req0_src2;
        sel_tag  = req0_tag;
        if (grant[1]) begin
            alu_op   = req1_op;
            alu_src1 = req1_src1;
            alu_src2 = req1_src2;
            sel_tag  = req1_tag;
        end
    end

    alu u_alu (
        .op     (alu_op),
        .src1   (alu_src1),
        .src2   (alu_src2),
        .result (alu_result)
    );

    assign op_ok            = onehot(alu_op);
    assign slot_result_next = op_ok ? alu_result : 32'h0;

    // Remember the winner of the latest grant; idle cycles leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
        end else if (grant[0]) begin
            last_grant_reg <= 1'b0;
        end else if (grant[1]) begin
            last_grant_reg <= 1'b1;
        end
    end

    // Count tie cycles, sticking at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt_reg <= '0;
        end else if ((&eligible) && (conflict_cnt_reg != {CNT_W{1'b1}})) begin
            conflict_cnt_reg <= conflict_cnt_reg + CNT_W'(1);
        end
    end

    assign conflict_cnt = conflict_cnt_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        // A port may be granted only when its slot is empty or draining now.
        assign eligible[gi] = req_valid[gi] & (~rsp_valid_reg[gi] | rsp_ready[gi]);

        // Response slot: refill on grant (even while draining), else clear on drain.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rsp_valid_reg[gi]  <= 1'b0;
                rsp_result_reg[gi] <= '0;
                rsp_tag_reg[gi]    <= '0;
                rsp_err_reg[gi]    <= 1'b0;
            end else if (grant[gi]) begin
                rsp_valid_reg[gi]  <= 1'b1;
                rsp_result_reg[gi] <= slot_result_next;
                rsp_tag_reg[gi]    <= sel_tag;
                rsp_err_reg[gi]    <= ~op_ok;
            end else if (rsp_ready[gi]) begin
                rsp_valid_reg[gi]  <= 1'b0;
            end
        end
    end

    assign rsp0_valid  = rsp_valid_reg[0];
    assign rsp0_result = rsp_result_reg[0];
    assign rsp0_tag    = rsp_tag_reg[0];
    assign rsp0_err    = rsp_err_reg[0];
    assign rsp1_valid  = rsp_valid_reg[1];
    assign rsp1_result = rsp_result_reg[1];
    assign rsp1_tag    = rsp_tag_reg[1];
    assign rsp1_err    = rsp_err_reg[1];

endmodule

// File: doc/alu_arb.md
Name: alu_arb

Overview:
- Shares one combinational ALU between two requesters, e.g. port 0 = EXE-stage integer ops, port 1 = address/branch helper.
- Each request port uses valid/ready. Grants are round-robin.
- Each requester has a one-entry registered response slot; a result is presented one cycle after acceptance.
- Also flags malformed (non-one-hot) op codes and counts arbitration conflicts.

Parameters:
- TAG_W, 4, width of the opaque tag carried from request to response.
- OP_W, 12, ALU op vector width; one-hot, fixed by the ALU encoding.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_op  in  OP_W  one-hot ALU op. Bits: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui.
- req0_src1  in  32  operand 1; shift amount in [4:0].
- req0_src2  in  32  operand 2; shifted value / lui immediate in [15:0].
- req0_tag  in  TAG_W  returned unchanged.
- req1_valid, req1_ready, req1_op, req1_src1, req1_src2, req1_tag: as port 0, for requester 1.
- rsp0_valid  out  1  response slot 0 holds a result.
- rsp0_ready  in  1  consumer 0 takes the result this cycle.
- rsp0_result  out  32  ALU result.
- rsp0_tag  out  TAG_W  tag of the originating request.
- rsp0_err  out  1  op was not exactly one-hot.
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_tag, rsp1_err: as rsp0, for requester 1.
- conflict_cnt  out  CNT_W  saturating count of cycles in which an eligible request lost arbitration.

Behaviour:
- Reset values: all rsp*_valid, rsp*_result, rsp*_tag, rsp*_err and conflict_cnt = 0; last_grant = 1, so port 0 wins the first conflict.
- Reset mid-operation discards all slot contents; nothing is replayed.
- Eligibility: eligible_i = reqi_valid & (~rspi_valid | rspi_ready), i.e. the slot is empty or draining this cycle.
- Grant:
  - Only one eligible: that port is granted.
  - Both eligible: grant goes to the port != last_grant.
  - reqi_ready = grant_i; it is combinational and depends on reqi_valid and rspi_ready.
  - last_grant updates only when a grant occurs.
- Operand mux: the ALU is fed from the granted port. With no grant, the port 0 operands are driven and the ALU result is ignored.
- Acceptance (grant_i at the edge):
  - rspi_result <= (op one-hot) ? alu_result : 32'h0.
  - rspi_err <= ~onehot(op).
  - rspi_tag <= tag; rspi_valid <= 1.
- Latency: 1 cycle from acceptance to rspi_valid.
- Throughput: 1 op/cycle aggregate, and 1 op/cycle per port when its consumer holds rspi_ready=1.
- Drain: rspi_valid & rspi_ready with no new grant_i -> rspi_valid <= 0. Drain and refill in the same cycle keeps valid=1 with the new data.
- Full slot (rspi_valid=1, rspi_ready=0): port i is not eligible, and the other port may take every cycle.
- Slot stability: result, tag and err are stable while rspi_valid=1 and rspi_ready=0.
- conflict_cnt: increments when both ports are eligible (one loses). It saturates at all-ones and never wraps.
- Arithmetic:
  - 32-bit wrap-around for add/sub.
  - slt signed, sltu unsigned, results 0/1.
  - sra sign-fills; srl and sll zero-fill.
  - lui = {src2[15:0], 16'h0}.
- op = 0 or multi-hot: err=1, result=0, the handshake completes normally.

Decomposition:
- Shared package alu_defs:
  - OP_W and the bit index constants (OP_ADD=0 … OP_LUI=11).
  - A onehot check function.
  - RSP_LAT=1.
- Natural sub-module: alu, the shared ALU instanced unchanged. All arbitration, slots and counters live in alu_arb.

Test Plan:
- Single port: req0 add src1=5 src2=7 tag=3 -> next cycle rsp0_valid=1, result=0x0000000C, tag=3, err=0; req1 idle, conflict_cnt=0.
- Both valid every cycle, rsp ready=1:
  - Stimulus: req0 sub 3,5; req1 sll src1=4 src2=1.
  - Grants alternate 0,1,0,1…; rsp0 result=0xFFFFFFFE, rsp1 result=0x10.
  - conflict_cnt increments each cycle.
- Backpressure: rsp0_ready=0 with rsp0_valid=1 -> req0_ready=0; req1 granted every cycle; rsp0 data held unchanged; raising rsp0_ready drains and refills in the same cycle.
- Malformed op: req1_op=12'h003 src1=1 src2=1 -> rsp1_err=1, result=0; slt 0xFFFFFFFF vs 1 -> 1; sltu -> 0; sra 0x80000000 by 4 -> 0xF8000000.
- Saturation: force 2^16+5 conflict cycles -> conflict_cnt=0xFFFF, held.
- Reset mid-stream: assert reset while rsp0_valid=1 -> rsp0_valid=0 immediately (async); after release, the first conflict grants port 0.
